// File: rtl/tournament_sequencer.sv
// Tournament sequencer: configures the rock-paper-scissors game core, relays player moves and keeps game tallies.
// Optional TOURNAMENT_SEQUENCER_ROUND_LOG_EN adds round_valid/round_result, a per-manche result pulse.
module tournament_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_rounds,
  input  logic [2:0] cfg_games,
  input  logic       mv_valid,
  output logic       mv_ready,
  input  logic [1:0] mv_p1,
  input  logic [1:0] mv_p2,
  output logic       INIZIA,
  output logic [1:0] PRIMO,
  output logic [1:0] SECONDO,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  input  logic       abort,
  output logic [2:0] games_p1,
  output logic [2:0] games_p2,
  output logic       done,
  output logic [1:0] WINNER
`ifdef TOURNAMENT_SEQUENCER_ROUND_LOG_EN
  ,
  output logic       round_valid,
  output logic [1:0] round_result
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RESTART,
    PLAY_WAIT,
    PLAY_ISSUE,
    DONE
  } state_e;

  state_e     state_q;
  logic       cfg_ready_q;
  logic       mv_ready_q;
  logic       inizia_q;
  logic [1:0] primo_q;
  logic [1:0] secondo_q;
  logic [3:0] rounds_q;
  logic [2:0] games_q;
  logic [2:0] played_q;
  logic [2:0] p1_q;
  logic [2:0] p2_q;
  logic       done_q;
  logic [1:0] winner_q;

  logic [2:0] played_d;
  logic [2:0] p1_d;
  logic [2:0] p2_d;
  logic [2:0] half_games;
  logic       game_over;
  logic [1:0] winner_d;

  // Tallies as they would stand if the game core reports a finished game this cycle.
  always_comb begin
    played_d   = played_q + 3'd1;
    p1_d       = p1_q + {2'b00, PARTITA == 2'b01};
    p2_d       = p2_q + {2'b00, PARTITA == 2'b10};
    half_games = games_q >> 1;
    game_over  = (played_d == games_q) || (p1_d > half_games) || (p2_d > half_games);
    if (p1_d > p2_d)      winner_d = 2'b01;
    else if (p2_d > p1_d) winner_d = 2'b10;
    else                  winner_d = 2'b11;
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_ready_q <= 1'b1;
      mv_ready_q  <= 1'b0;
      inizia_q    <= 1'b0;
      primo_q     <= 2'b00;
      secondo_q   <= 2'b00;
      rounds_q    <= 4'd0;
      games_q     <= 3'd1;
      played_q    <= 3'd0;
      p1_q        <= 3'd0;
      p2_q        <= 3'd0;
      done_q      <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      // Core drive is idle (INIZIA=0, moves 00) unless a cycle below issues something.
      inizia_q  <= 1'b0;
      primo_q   <= 2'b00;
      secondo_q <= 2'b00;
      if (abort) begin
        state_q     <= IDLE;
        cfg_ready_q <= 1'b1;
        mv_ready_q  <= 1'b0;
        played_q    <= 3'd0;
        p1_q        <= 3'd0;
        p2_q        <= 3'd0;
        done_q      <= 1'b0;
        winner_q    <= 2'b00;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (cfg_valid) begin
              rounds_q    <= cfg_rounds;
              games_q     <= (cfg_games == 3'd0) ? 3'd1 : cfg_games;
              played_q    <= 3'd0;
              p1_q        <= 3'd0;
              p2_q        <= 3'd0;
              done_q      <= 1'b0;
              winner_q    <= 2'b00;
              cfg_ready_q <= 1'b0;
              inizia_q    <= 1'b1;
              primo_q     <= cfg_rounds[3:2];
              secondo_q   <= cfg_rounds[1:0];
              state_q     <= RESTART;
            end
          end
          RESTART: begin
            mv_ready_q <= 1'b1;
            state_q    <= PLAY_WAIT;
          end
          PLAY_WAIT: begin
            if (mv_valid) begin
              mv_ready_q <= 1'b0;
              primo_q    <= mv_p1;
              secondo_q  <= mv_p2;
              state_q    <= PLAY_ISSUE;
            end
          end
          PLAY_ISSUE: begin
            if (PARTITA == 2'b00) begin
              mv_ready_q <= 1'b1;
              state_q    <= PLAY_WAIT;
            end else begin
              played_q <= played_d;
              p1_q     <= p1_d;
              p2_q     <= p2_d;
              if (game_over) begin
                done_q      <= 1'b1;
                winner_q    <= winner_d;
                cfg_ready_q <= 1'b1;
                state_q     <= DONE;
              end else begin
                inizia_q  <= 1'b1;
                primo_q   <= rounds_q[3:2];
                secondo_q <= rounds_q[1:0];
                state_q   <= RESTART;
              end
            end
          end
          default: begin
            cfg_ready_q <= 1'b1;
            mv_ready_q  <= 1'b0;
            state_q     <= IDLE;
          end
        endcase
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign mv_ready  = mv_ready_q;
  assign INIZIA    = inizia_q;
  assign PRIMO     = primo_q;
  assign SECONDO   = secondo_q;
  assign games_p1  = p1_q;
  assign games_p2  = p2_q;
  assign done      = done_q;
  assign WINNER    = winner_q;

`ifdef TOURNAMENT_SEQUENCER_ROUND_LOG_EN
  logic       round_valid_q;
  logic [1:0] round_result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_valid_q  <= 1'b0;
      round_result_q <= 2'b00;
    end else begin
      round_valid_q  <= (state_q == PLAY_ISSUE) && !abort;
      round_result_q <= ((state_q == PLAY_ISSUE) && !abort) ? MANCHE : 2'b00;
    end
  end

  assign round_valid  = round_valid_q;
  assign round_result = round_result_q;
`else
  // MANCHE only feeds the round log; without it the input is intentionally left unread.
  logic manche_unused;
  assign manche_unused = ^MANCHE;
`endif

endmodule

// File: tb/tb_tournament_sequencer.sv
// Scoreboard bench for tournament_sequencer: directed corner cases plus random tournaments
// checked against a game-level tally model.
module tb_tournament_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_rounds = 4'd0;
  logic [2:0] cfg_games = 3'd0;
  logic       mv_valid = 1'b0;
  logic       mv_ready;
  logic [1:0] mv_p1 = 2'b00;
  logic [1:0] mv_p2 = 2'b00;
  logic       INIZIA;
  logic [1:0] PRIMO;
  logic [1:0] SECONDO;
  logic [1:0] MANCHE = 2'b00;
  logic [1:0] PARTITA = 2'b00;
  logic       abort = 1'b0;
  logic [2:0] games_p1;
  logic [2:0] games_p2;
  logic       done;
  logic [1:0] WINNER;
`ifdef TOURNAMENT_SEQUENCER_ROUND_LOG_EN
  logic       round_valid;
  logic [1:0] round_result;
`endif

  tournament_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_rounds(cfg_rounds),
    .cfg_games (cfg_games),
    .mv_valid  (mv_valid),
    .mv_ready  (mv_ready),
    .mv_p1     (mv_p1),
    .mv_p2     (mv_p2),
    .INIZIA    (INIZIA),
    .PRIMO     (PRIMO),
    .SECONDO   (SECONDO),
    .MANCHE    (MANCHE),
    .PARTITA   (PARTITA),
    .abort     (abort),
    .games_p1  (games_p1),
    .games_p2  (games_p2),
    .done      (done),
    .WINNER    (WINNER)
`ifdef TOURNAMENT_SEQUENCER_ROUND_LOG_EN
    ,
    .round_valid (round_valid),
    .round_result(round_result)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [1:0] EV_RESTART = 2'd1;
  localparam logic [1:0] EV_MOVE    = 2'd2;
  localparam logic [1:0] EV_END     = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Game-level reference model of the running tournament.
  logic [3:0] m_rounds;
  int         m_games;
  int         m_p1;
  int         m_p2;
  int         m_played;
  bit         m_done;

  logic [1:0] hold_p1 [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  logic [1:0] hold_p2 [4] = '{2'b11, 2'b01, 2'b10, 2'b10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_restart(input logic [3:0] r);
    push_ev(EV_RESTART, {1'b1, 1'b0, r, 2'b00});
  endtask

  task automatic push_move(input logic [1:0] p1, input logic [1:0] p2);
    push_ev(EV_MOVE, {1'b0, 1'b0, p1, p2, 2'b00});
  endtask

  task automatic observe(input logic [1:0] kind, input logic [7:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("sb_unexpected_event", 32'(kind), 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("sb_event", 32'({kind, data}), 32'({e.kind, e.data}));
  endtask

  // Apply one finished-game report to the model and predict what follows it.
  task automatic model_result(input logic [1:0] par);
    logic [1:0] win;
    if (par != 2'b00) begin
      m_played++;
      if (par == 2'b01) m_p1++;
      else if (par == 2'b10) m_p2++;
      if (m_played == m_games || m_p1 > m_games / 2 || m_p2 > m_games / 2) begin
        m_done = 1'b1;
        if (m_p1 > m_p2)      win = 2'b01;
        else if (m_p2 > m_p1) win = 2'b10;
        else                  win = 2'b11;
        push_ev(EV_END, {3'(m_p1), 3'(m_p2), win});
      end else begin
        push_restart(m_rounds);
      end
    end
  endtask

  task automatic do_config(input logic [3:0] r, input logic [2:0] g);
    int t = 0;
    while (!cfg_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_valid  = 1'b1;
    cfg_rounds = r;
    cfg_games  = g;
    push_restart(r);
    m_rounds = r;
    m_games  = (g == 3'd0) ? 1 : int'(g);
    m_p1     = 0;
    m_p2     = 0;
    m_played = 0;
    m_done   = 1'b0;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("cfg_lat_inizia", 32'(INIZIA), 32'd1);
    check("cfg_lat_mv_ready_early", 32'(mv_ready), 32'd0);
    @(posedge clk); #1;
    check("cfg_lat_mv_ready", 32'(mv_ready), 32'd1);
  endtask

  task automatic play_move(input logic [1:0] p1, input logic [1:0] p2,
                           input logic [1:0] man, input logic [1:0] par);
    int t = 0;
    while (!mv_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("mv_ready_wait", 32'(mv_ready), 32'd1);
    mv_valid = 1'b1;
    mv_p1    = p1;
    mv_p2    = p2;
    push_move(p1, p2);
    @(posedge clk); #1;
    mv_valid = 1'b0;
    MANCHE   = man;
    PARTITA  = par;
    model_result(par);
    @(posedge clk); #1;
    MANCHE  = 2'b00;
    PARTITA = 2'b00;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    check({tag, "_mv_ready"}, 32'(mv_ready), 32'd0);
    check({tag, "_drive"}, 32'({INIZIA, PRIMO, SECONDO}), 32'd0);
    check({tag, "_tallies"}, 32'({games_p1, games_p2}), 32'd0);
    check({tag, "_done_winner"}, 32'({done, WINNER}), 32'd0);
  endtask

  // Monitor: samples on the falling edge and matches each core drive or tournament end
  // against the head of the expectation queue.
  bit         pend_move = 1'b0;
  bit         done_prev = 1'b0;
`ifdef TOURNAMENT_SEQUENCER_ROUND_LOG_EN
  bit         pend_round = 1'b0;
  logic [1:0] pend_manche = 2'b00;
`endif

  always @(negedge clk) begin
    if (rst) begin
      pend_move = 1'b0;
      done_prev = 1'b0;
`ifdef TOURNAMENT_SEQUENCER_ROUND_LOG_EN
      pend_round = 1'b0;
`endif
    end else begin
`ifdef TOURNAMENT_SEQUENCER_ROUND_LOG_EN
      if (pend_round) check("round_log", 32'({round_valid, round_result}), 32'({1'b1, pend_manche}));
      else            check("round_log_idle", 32'(round_valid), 32'd0);
      pend_round  = pend_move;
      pend_manche = MANCHE;
`endif
      if (pend_move)   observe(EV_MOVE, {INIZIA, 1'b0, PRIMO, SECONDO, 2'b00});
      else if (INIZIA) observe(EV_RESTART, {INIZIA, 1'b0, PRIMO, SECONDO, 2'b00});
      else             check("idle_drive", 32'({PRIMO, SECONDO}), 32'd0);
      if (done && !done_prev) observe(EV_END, {games_p1, games_p2, WINNER});
      done_prev = done;
      pend_move = mv_valid && mv_ready && !abort;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [1:0] par;
    int r;

    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Minimum-size tournament with mv_valid held high: ready toggles every cycle,
    // the fourth move finishes the only game in P2's favour.
    do_config(4'b0001, 3'd1);
    mv_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mv_p1 = hold_p1[k];
      mv_p2 = hold_p2[k];
      push_move(mv_p1, mv_p2);
      check("hold_ready_hi", 32'(mv_ready), 32'd1);
      @(posedge clk); #1;
      check("hold_ready_lo", 32'(mv_ready), 32'd0);
      if (k == 3) mv_valid = 1'b0;
      MANCHE  = 2'(k);
      PARTITA = (k == 3) ? 2'b10 : 2'b00;
      model_result(PARTITA);
      @(posedge clk); #1;
      MANCHE  = 2'b00;
      PARTITA = 2'b00;
    end
    check("single_game_result", 32'({done, cfg_ready, games_p1, games_p2, WINNER}),
          32'({1'b1, 1'b1, 3'd0, 3'd1, 2'b10}));

    // Best of three: two P1 wins end it early with no third restart.
    do_config(4'b0110, 3'd3);
    play_move(2'b01, 2'b11, 2'b01, 2'b00);
    play_move(2'b10, 2'b01, 2'b01, 2'b01);
    play_move(2'b11, 2'b10, 2'b01, 2'b01);
    repeat (4) @(posedge clk);
    #1;
    check("early_end_result", 32'({done, games_p1, games_p2, WINNER}),
          32'({1'b1, 3'd2, 3'd0, 2'b01}));

    // Two games split one each: a drawn tournament.
    do_config(4'b1011, 3'd2);
    play_move(2'b01, 2'b11, 2'b01, 2'b01);
    play_move(2'b00, 2'b10, 2'b00, 2'b00);
    play_move(2'b10, 2'b11, 2'b10, 2'b10);
    check("draw_result", 32'({done, games_p1, games_p2, WINNER}),
          32'({1'b1, 3'd1, 3'd1, 2'b11}));

    // Abort beats a simultaneous config handshake.
    abort     = 1'b1;
    cfg_valid = 1'b1;
    cfg_rounds = 4'b1111;
    cfg_games  = 3'd5;
    @(posedge clk); #1;
    abort     = 1'b0;
    cfg_valid = 1'b0;
    check_idle_outputs("abort_vs_cfg");
    @(posedge clk); #1;
    check("abort_vs_cfg_no_restart", 32'({INIZIA, mv_ready}), 32'd0);

    // cfg_games=0 behaves as a single game; a drawn game ends it.
    do_config(4'b0000, 3'd0);
    play_move(2'b01, 2'b01, 2'b11, 2'b11);
    check("zero_games_result", 32'({done, games_p1, games_p2, WINNER}),
          32'({1'b1, 3'd0, 3'd0, 2'b11}));

    // Abort while waiting for a move after one finished game.
    do_config(4'b0101, 3'd3);
    play_move(2'b10, 2'b01, 2'b01, 2'b01);
    n = 0;
    while (!mv_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("pre_abort_tally", 32'({mv_ready, games_p1}), 32'({1'b1, 3'd1}));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_idle_outputs("abort_play_wait");

    // Reset arriving while a move is being driven to the core.
    do_config(4'b1110, 3'd3);
    mv_valid = 1'b1;
    mv_p1    = 2'b11;
    mv_p2    = 2'b01;
    push_move(mv_p1, mv_p2);
    @(posedge clk); #1;
    mv_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_idle_outputs("reset_mid_issue");
    @(posedge clk); #1;
    rst = 1'b0;
    mv_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_reset_no_mv_ready", 32'({mv_ready, INIZIA}), 32'd0);
    end
    mv_valid = 1'b0;

    // Random tournaments against the model.
    for (int t = 0; t < 8; t++) begin
      do_config(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      n = 0;
      while (!m_done && n < 200) begin
        r = int'($urandom_range(0, 5));
        par = (r < 3) ? 2'b00 : 2'(r - 2);
        play_move(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), par);
        n++;
      end
      check("rand_done", 32'({done, cfg_ready}), 32'({1'b1, 1'b1}));
    end

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
